// File: rtl/i2c_fnv_pkg.sv
// Shared constants and types for the I2C FNV-1a hash peripheral.
package i2c_fnv_pkg;

  localparam logic [31:0] FNV_PRIME_32 = 32'h0100_0193;
  localparam logic [63:0] FNV_PRIME_64 = 64'h0000_0100_0000_01B3;
  localparam logic [31:0] FNV_BASIS_32 = 32'h811C_9DC5;
  localparam logic [63:0] FNV_BASIS_64 = 64'hCBF2_9CE4_8422_2325;

  typedef enum logic [1:0] {OP_CLEAR, OP_ABSORB, OP_SELECT, OP_RSVD} op_e;

  typedef enum logic {NONE, ABSORB} mode_e;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } i2c_state_e;

endpackage

// File: rtl/fnv1a_lane.sv
// One FNV-1a hash lane: xor a byte in, multiply by the FNV prime, truncate to HASH_W.
module fnv1a_lane #(
  parameter int unsigned HASH_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [7:0]        din,
  output logic [HASH_W-1:0] hash
);
  import i2c_fnv_pkg::*;

  localparam logic [HASH_W-1:0] PRIME =
      (HASH_W == 64) ? HASH_W'(FNV_PRIME_64) : HASH_W'(FNV_PRIME_32);
  localparam logic [HASH_W-1:0] BASIS =
      (HASH_W == 64) ? HASH_W'(FNV_BASIS_64) : HASH_W'(FNV_BASIS_32);

  logic [HASH_W-1:0] mixed, prod;

  // Constant multiply: only the set bits of PRIME contribute a shifted term.
  always_comb begin
    mixed = hash ^ HASH_W'(din);
    prod  = '0;
    for (int i = 0; i < HASH_W; i++) begin
      if (PRIME[i]) prod = prod + (mixed << i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) hash <= BASIS;
    else if (en)      hash <= prod;
  end

endmodule

// File: rtl/i2c_fnv1a_multi_periph.sv
// Oversampled I2C target exposing NUM_CH FNV-1a lanes: writes absorb bytes, reads return a digest.
module i2c_fnv1a_multi_periph #(
  parameter logic [6:0]  I2C_ADDR = 7'h2A,
  parameter int unsigned HASH_W   = 32,
  parameter int unsigned NUM_CH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       busy,
  output logic       hash_upd,
  output logic [5:0] upd_ch
);
  import i2c_fnv_pkg::*;

  localparam int         NBYTES   = HASH_W / 8;
  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);
  localparam logic [6:0] NUM_CH_W = 7'(NUM_CH);

  logic [2:0] scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det, sda_bit;

  // Sync resets to the idle-bus level so reset release never looks like START.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s <= 3'b111;
      sda_s <= 3'b111;
    end else begin
      scl_s <= {scl_s[1:0], scl_i};
      sda_s <= {sda_s[1:0], sda_i};
    end
  end

  assign scl_rise  = scl_s[1] & ~scl_s[2];
  assign scl_fall  = ~scl_s[1] & scl_s[2];
  assign start_det = scl_s[1] & scl_s[2] & sda_s[2] & ~sda_s[1];
  assign stop_det  = scl_s[1] & scl_s[2] & ~sda_s[2] & sda_s[1];
  assign sda_bit   = sda_s[1];

  i2c_state_e        state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              done_q, done_d, ack_q, ack_d, rw_q, rw_d;
  logic              sda_oe_q, sda_oe_d, busy_q, busy_d;
  mode_e             mode_q, mode_d;
  logic [5:0]        sel_ch_q, sel_ch_d;
  logic [2:0]        rd_idx_q, rd_idx_d, nxt_idx;
  logic [HASH_W-1:0] shadow_q, shadow_d, sel_hash;
  logic [7:0]        cur_byte, nxt_byte;
  logic [NUM_CH-1:0] clr, lane_en;
  logic [HASH_W-1:0] lane_hash [NUM_CH];
  op_e               op;
  logic [5:0]        cmd_ch;
  logic              cmd_ok;

  assign hash_upd = done_q && (state_q == WDATA) && (mode_q == ABSORB);
  assign upd_ch   = hash_upd ? sel_ch_q : 6'd0;
  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign op       = op_e'(shreg_q[7:6]);
  assign cmd_ch   = shreg_q[5:0];
  assign cmd_ok   = (op != OP_RSVD) && ({1'b0, cmd_ch} < NUM_CH_W);
  assign nxt_idx  = (rd_idx_q == LAST_IDX) ? 3'd0 : rd_idx_q + 3'd1;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    fnv1a_lane #(.HASH_W(HASH_W)) u_lane (
      .clk  (clk),
      .reset(reset),
      .clr  (clr[g]),
      .en   (lane_en[g]),
      .din  (shreg_q),
      .hash (lane_hash[g])
    );
  end

  always_comb begin
    sel_hash = lane_hash[0];
    lane_en  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_ch_q == i[5:0]) sel_hash = lane_hash[i];
      lane_en[i] = hash_upd && (sel_ch_q == i[5:0]);
    end
  end

  always_comb begin
    cur_byte = shadow_q[HASH_W-1 -: 8];
    nxt_byte = shadow_q[HASH_W-1 -: 8];
    for (int i = 0; i < NBYTES; i++) begin
      if (rd_idx_q == i[2:0]) cur_byte = shadow_q[HASH_W-1-8*i -: 8];
      if (nxt_idx == i[2:0])  nxt_byte = shadow_q[HASH_W-1-8*i -: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    ack_d     = ack_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    mode_d    = mode_q;
    sel_ch_d  = sel_ch_q;
    rd_idx_d  = rd_idx_q;
    shadow_d  = shadow_q;
    clr       = '0;
    if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      // Byte-complete decisions land one clk after the 8th sample, ahead of the ACK slot.
      if (done_q) begin
        case (state_q)
          ADDR: begin
            ack_d = (shreg_q[7:1] == I2C_ADDR);
            rw_d  = shreg_q[0];
            if (ack_d) busy_d = 1'b1;
            if (ack_d && shreg_q[0]) begin
              shadow_d = sel_hash;
              rd_idx_d = '0;
            end
          end
          CMD: begin
            ack_d = cmd_ok;
            if (cmd_ok) begin
              case (op)
                OP_CLEAR: begin
                  mode_d = NONE;
                  for (int i = 0; i < NUM_CH; i++) clr[i] = (cmd_ch == i[5:0]);
                end
                OP_ABSORB: begin
                  sel_ch_d = cmd_ch;
                  mode_d   = ABSORB;
                end
                OP_SELECT: begin
                  sel_ch_d = cmd_ch;
                  mode_d   = NONE;
                end
                default: ;
              endcase
            end
          end
          WDATA:   ack_d = 1'b1;
          default: ;
        endcase
      end
      case (state_q)
        ADDR, CMD, WDATA: begin
          if (scl_rise && (bit_cnt_q != 4'd8)) begin
            shreg_d   = {shreg_q[6:0], sda_bit};
            bit_cnt_d = bit_cnt_q + 4'd1;
            done_d    = (bit_cnt_q == 4'd7);
          end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
            bit_cnt_d = '0;
            sda_oe_d  = ack_q;
            if (!ack_q)                state_d = IGNORE;
            else if (state_q == ADDR)  state_d = ADDR_ACK;
            else if (state_q == CMD)   state_d = CMD_ACK;
            else                       state_d = WDATA_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            state_d  = rw_q ? RDATA : CMD;
            sda_oe_d = rw_q ? ~cur_byte[7] : 1'b0;
          end
        end
        CMD_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_d  = WDATA;
            sda_oe_d = 1'b0;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d  = RDATA_ACK;
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~cur_byte[3'd7 - bit_cnt_q[2:0]];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            ack_d = ~sda_bit;
          end else if (scl_fall) begin
            bit_cnt_d = '0;
            if (ack_q) begin
              state_d  = RDATA;
              rd_idx_d = nxt_idx;
              sda_oe_d = ~nxt_byte[7];
            end else begin
              state_d  = IGNORE;
              sda_oe_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      mode_q    <= NONE;
      sel_ch_q  <= '0;
      rd_idx_q  <= '0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      mode_q    <= mode_d;
      sel_ch_q  <= sel_ch_d;
      rd_idx_q  <= rd_idx_d;
      shadow_q  <= shadow_d;
    end
  end

endmodule

// File: tb/tb_i2c_fnv1a_multi_periph.sv
// Directed bench: a bit-banged I2C master on a shared wired-AND bus with a 32-bit and a 64-bit target.
module tb_i2c_fnv1a_multi_periph;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       reset, scl, sda_m;
  logic       oe32, busy32, upd32, oe64, busy64, upd64;
  logic [5:0] ch32, ch64;
  wire        sda_line = sda_m & ~oe32 & ~oe64;

  int         n_checks = 0, n_fail = 0, upd_cnt = 0, oe_cnt = 0, base;
  logic [5:0] last_ch = '0;
  logic       a;
  logic [7:0] d;
  logic       b;

  always #5 clk = ~clk;

  i2c_fnv1a_multi_periph #(.I2C_ADDR(7'h2A), .HASH_W(32), .NUM_CH(4)) dut32 (
    .clk(clk), .reset(reset), .scl_i(scl), .sda_i(sda_line),
    .sda_oe(oe32), .busy(busy32), .hash_upd(upd32), .upd_ch(ch32)
  );

  i2c_fnv1a_multi_periph #(.I2C_ADDR(7'h3C), .HASH_W(64), .NUM_CH(2)) dut64 (
    .clk(clk), .reset(reset), .scl_i(scl), .sda_i(sda_line),
    .sda_oe(oe64), .busy(busy64), .hash_upd(upd64), .upd_ch(ch64)
  );

  always @(posedge clk) begin
    if (upd32) begin
      upd_cnt = upd_cnt + 1;
      last_ch = ch32;
    end
    if (oe32) oe_cnt = oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic put_bit(input logic v);
    sda_m = v;    wait_q();
    scl   = 1'b1; wait_q(); wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic get_bit(output logic v);
    sda_m = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    v     = sda_line; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic put_byte(input logic [7:0] v, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(s);
    ack = ~s;
  endtask

  task automatic get_byte(output logic [7:0] v, input logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      get_bit(s);
      v[i] = s;
    end
    put_bit(~ack);
  endtask

  task automatic wr(input logic [7:0] v, input logic exp_ack, input string tag);
    logic k;
    put_byte(v, k);
    check(tag, k, exp_ack);
  endtask

  task automatic write_cmd(input logic [7:0] cmd, input logic exp_ack, input string tag);
    i2c_start();
    wr(8'h54, 1'b1, {tag, " addr ack"});
    wr(cmd, exp_ack, {tag, " cmd ack"});
    i2c_stop();
  endtask

  task automatic read_word(input logic [7:0] addr, input int nb, input string tag,
                           input logic [63:0] exp);
    logic [7:0]  v;
    logic [63:0] w;
    w = '0;
    i2c_start();
    wr(addr, 1'b1, {tag, " addr ack"});
    for (int i = 0; i < nb; i++) begin
      get_byte(v, i != nb - 1);
      w = {w[55:0], v};
    end
    i2c_stop();
    check(tag, w, exp);
  endtask

  initial begin
    reset = 1'b1;
    scl   = 1'b1;
    sda_m = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset sda_oe", oe32, 1'b0);
    check("reset busy", busy32, 1'b0);
    check("reset hash_upd", upd32, 1'b0);
    check("reset upd_ch", ch32, 6'd0);
    reset = 1'b0;
    wait_q();

    // 1: basis readback with wrap after the last byte
    i2c_start();
    wr(8'h55, 1'b1, "t1 addr ack");
    check("t1 busy", busy32, 1'b1);
    get_byte(d, 1'b1); check("t1 byte0", d, 8'h81);
    get_byte(d, 1'b1); check("t1 byte1", d, 8'h1C);
    get_byte(d, 1'b1); check("t1 byte2", d, 8'h9D);
    get_byte(d, 1'b1); check("t1 byte3", d, 8'hC5);
    get_byte(d, 1'b0); check("t1 wrap", d, 8'h81);
    i2c_stop();
    check("t1 busy after stop", busy32, 1'b0);

    // 2: absorb 'a' into lane 0
    base = upd_cnt;
    i2c_start();
    wr(8'h54, 1'b1, "t2 addr ack");
    wr(8'h40, 1'b1, "t2 cmd ack");
    wr(8'h61, 1'b1, "t2 data ack");
    i2c_stop();
    check("t2 upd count", 64'(upd_cnt - base), 64'd1);
    check("t2 upd_ch", last_ch, 6'd0);
    read_word(8'h55, 4, "t2 hash a", 64'hE40C292C);

    // 3: clear lane 0, absorb "foobar" into lane 2, others untouched
    write_cmd(8'h00, 1'b1, "t3 clear0");
    base = upd_cnt;
    i2c_start();
    wr(8'h54, 1'b1, "t3 addr ack");
    wr(8'h42, 1'b1, "t3 cmd ack");
    wr(8'h66, 1'b1, "t3 f");
    wr(8'h6F, 1'b1, "t3 o");
    wr(8'h6F, 1'b1, "t3 o");
    wr(8'h62, 1'b1, "t3 b");
    wr(8'h61, 1'b1, "t3 a");
    wr(8'h72, 1'b1, "t3 r");
    i2c_stop();
    check("t3 upd count", 64'(upd_cnt - base), 64'd6);
    check("t3 upd_ch", last_ch, 6'd2);
    read_word(8'h55, 4, "t3 hash foobar", 64'hBF9CF968);
    write_cmd(8'h80, 1'b1, "t3 sel0");
    read_word(8'h55, 4, "t3 lane0 basis", 64'h811C9DC5);
    write_cmd(8'h81, 1'b1, "t3 sel1");
    read_word(8'h55, 4, "t3 lane1 basis", 64'h811C9DC5);
    write_cmd(8'h83, 1'b1, "t3 sel3");
    read_word(8'h55, 4, "t3 lane3 basis", 64'h811C9DC5);

    // 4: illegal commands and foreign address
    write_cmd(8'hC0, 1'b0, "t4 op11");
    write_cmd(8'h45, 1'b0, "t4 ch5");
    base = oe_cnt;
    i2c_start();
    wr(8'h56, 1'b0, "t4 foreign addr");
    i2c_stop();
    check("t4 no sda_oe", 64'(oe_cnt - base), 64'd0);

    // 5: partial byte then STOP; repeated START mid-read
    base = upd_cnt;
    i2c_start();
    wr(8'h54, 1'b1, "t5 addr ack");
    wr(8'h41, 1'b1, "t5 cmd ack");
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    i2c_stop();
    check("t5 no upd", 64'(upd_cnt - base), 64'd0);
    read_word(8'h55, 4, "t5 lane1 basis", 64'h811C9DC5);
    i2c_start();
    wr(8'h55, 1'b1, "t5 rd addr ack");
    get_byte(d, 1'b1); check("t5 byte0", d, 8'h81);
    get_bit(b); get_bit(b); get_bit(b);
    check("t5 partial bit", b, 1'b0);
    i2c_start();
    wr(8'h55, 1'b1, "t5 restart ack");
    get_byte(d, 1'b0); check("t5 restart byte0", d, 8'h81);
    i2c_stop();

    // 6: 64-bit lane, then reset mid-read
    i2c_start();
    wr(8'h78, 1'b1, "t6 addr ack");
    wr(8'h40, 1'b1, "t6 cmd ack");
    wr(8'h61, 1'b1, "t6 data ack");
    i2c_stop();
    read_word(8'h79, 8, "t6 hash64 a", 64'hAF63DC4C8601EC8C);
    i2c_start();
    wr(8'h79, 1'b1, "t6 rd addr ack");
    get_byte(d, 1'b1); check("t6 byte0", d, 8'hAF);
    check("t6 oe before reset", oe64, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6 oe after reset", oe64, 1'b0);
    check("t6 busy after reset", busy64, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_q();
    i2c_stop();
    read_word(8'h79, 8, "t6 basis64", 64'hCBF29CE484222325);
    read_word(8'h55, 4, "t6 basis32", 64'h811C9DC5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
